// File: rtl/mac_pkg.sv
// Shared constants for the FP MAC accumulate stage: FSM encodings,
// symmetric saturation rails and default datapath sizing.
package mac_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ACC_W_DEF     = 24;
  localparam int NUM_TERMS_DEF = 4;
  localparam int CNT_W_DEF     = 3;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCUM  = 2'b01;
  localparam logic [1:0] ST_OUTPUT = 2'b10;

  // 0x8000 is deliberately never produced so the result range stays symmetric.
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8001;

endpackage

// File: rtl/mac_accumulator_sat_trunc.sv
// Symmetric saturating narrower: clamps a signed IN_W value into
// +/-(2^(OUT_W-1)-1) and flags when the clamp was applied.
module sat_trunc #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  wide_val,
  output logic        [OUT_W-1:0] narrow_val,
  output logic                    sat_flag
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-2){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] POS_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_V = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  // Clamp to the symmetric rails, otherwise pass the low bits through.
  always_comb begin
    narrow_val = wide_val[OUT_W-1:0];
    sat_flag   = 1'b0;
    if (wide_val > MAX_V) begin
      narrow_val = POS_V;
      sat_flag   = 1'b1;
    end else if (wide_val < MIN_V) begin
      narrow_val = NEG_V;
      sat_flag   = 1'b1;
    end else begin
      narrow_val = wide_val[OUT_W-1:0];
      sat_flag   = 1'b0;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// AC stage of the FP MAC datapath: sums NUM_TERMS saturated products in a
// widened accumulator and hands out one symmetric-saturated result.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int NUM_TERMS = NUM_TERMS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              prod_valid,
  input  logic [DATA_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              acc_valid,
  output logic [DATA_W-1:0] acc_data,
  output logic              acc_sat,
  input  logic              acc_ready,
  output logic              busy,
  output logic [1:0]        state_out
);

  logic [1:0]              state_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    acc_valid_r;
  logic [DATA_W-1:0]       acc_data_r;
  logic                    acc_sat_r;

  logic                    prod_ready_s;
  logic                    prod_hs_s;
  logic                    last_term_s;
  logic [ACC_W-1:0]        prod_ext_s;
  logic signed [ACC_W:0]   sum_wide_s;
  logic signed [ACC_W-1:0] next_acc_s;
  logic                    acc_clamp_s;
  logic [DATA_W-1:0]       result_s;
  logic                    result_sat_s;

  assign prod_ready_s = (state_r == ST_ACCUM) && !clear;
  assign prod_hs_s    = prod_valid && prod_ready_s;
  assign last_term_s  = prod_hs_s && (cnt_r == CNT_W'(NUM_TERMS - 1));

  // One guard bit lets the accumulator clamp instead of wrapping.
  assign prod_ext_s = {{(ACC_W-DATA_W){prod_data[DATA_W-1]}}, prod_data};
  assign sum_wide_s = {acc_r[ACC_W-1], acc_r} + {prod_ext_s[ACC_W-1], prod_ext_s};

  sat_trunc #(
    .IN_W  (ACC_W + 1),
    .OUT_W (ACC_W)
  ) u_acc_sat (
    .wide_val   (sum_wide_s),
    .narrow_val (next_acc_s),
    .sat_flag   (acc_clamp_s)
  );

  sat_trunc #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_out_sat (
    .wide_val   (next_acc_s),
    .narrow_val (result_s),
    .sat_flag   (result_sat_s)
  );

  // Run control FSM plus accumulator, term counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      acc_valid_r <= 1'b0;
      acc_data_r  <= '0;
      acc_sat_r   <= 1'b0;
    end else if (clear) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      acc_valid_r <= 1'b0;
      acc_sat_r   <= 1'b0;
      case (state_r)
        ST_IDLE:   state_r <= start ? ST_ACCUM : ST_IDLE;
        ST_ACCUM:  state_r <= ST_ACCUM;
        ST_OUTPUT: state_r <= ST_ACCUM;
        default:   state_r <= ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_ACCUM;
            acc_r   <= '0;
            cnt_r   <= '0;
          end
        end
        ST_ACCUM: begin
          if (prod_hs_s) begin
            acc_r <= next_acc_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_term_s) begin
              // An accumulator clamp always implies an output clamp as well.
              acc_data_r  <= result_s;
              acc_sat_r   <= result_sat_s | acc_clamp_s;
              acc_valid_r <= 1'b1;
              state_r     <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (acc_ready) begin
            acc_valid_r <= 1'b0;
            acc_r       <= '0;
            cnt_r       <= '0;
            state_r     <= ST_ACCUM;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          acc_r       <= '0;
          cnt_r       <= '0;
          acc_valid_r <= 1'b0;
          acc_sat_r   <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = prod_ready_s;
  assign acc_valid  = acc_valid_r;
  assign acc_data   = acc_data_r;
  assign acc_sat    = acc_sat_r;
  assign busy       = (state_r != ST_IDLE);
  assign state_out  = state_r;

endmodule
